// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: hazard sources in, stall/flush/freeze controls and counters out.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             memRead_E;
  logic [4:0]       Rd_E;
  logic [4:0]       Rn_D;
  logic [4:0]       Rm_D;
  logic             useRm_D;
  logic             PCSrc_M;
  logic             dmem_req_M;
  logic             dmem_ack;
  logic             stall_F;
  logic             stall_D;
  logic             flush_D;
  logic             flush_E;
  logic             flush_M;
  logic             freeze;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output memRead_E, Rd_E, Rn_D, Rm_D, useRm_D, PCSrc_M, dmem_req_M, dmem_ack,
    input  stall_F, stall_D, flush_D, flush_E, flush_M, freeze, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  memRead_E, Rd_E, Rn_D, Rm_D, useRm_D, PCSrc_M, dmem_req_M, dmem_ack,
    output stall_F, stall_D, flush_D, flush_E, flush_M, freeze, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// LEGv8 five-stage hazard controller: load-use stalls, taken-branch flushes,
// data-memory wait freeze with timeout, and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  hazard_ctrl_if.slave bus
);
  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [WCNT_W-1:0] r_wcnt;
  logic [WCNT_W-1:0] w_wcnt_nxt;
  logic              r_mem_err;
  logic              w_set_err;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              w_lu;
  logic              w_flush_acc;
  logic              w_stall_F;
  logic              w_stall_D;
  logic              w_flush_D;
  logic              w_flush_E;
  logic              w_flush_M;
  logic              w_freeze;

  // XZR never carries a real dependence, so it is excluded from the hazard compare.
  assign w_lu = bus.memRead_E && (bus.Rd_E != 5'd31) &&
                ((bus.Rn_D == bus.Rd_E) || (bus.useRm_D && (bus.Rm_D == bus.Rd_E)));

  always_comb begin
    w_stall_F   = 1'b0;
    w_stall_D   = 1'b0;
    w_flush_D   = 1'b0;
    w_flush_E   = 1'b0;
    w_flush_M   = 1'b0;
    w_freeze    = 1'b0;
    w_flush_acc = 1'b0;
    w_set_err   = 1'b0;
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    if (!reset) begin
      case (r_state)
        RUN: begin
          if (bus.dmem_req_M && !bus.dmem_ack) begin
            w_freeze    = 1'b1;
            w_state_nxt = MEM_WAIT;
            w_wcnt_nxt  = WCNT_W'(1);
          end else if (bus.PCSrc_M) begin
            w_flush_D   = 1'b1;
            w_flush_E   = 1'b1;
            w_flush_M   = 1'b1;
            w_flush_acc = 1'b1;
          end else if (w_lu) begin
            w_stall_F = 1'b1;
            w_stall_D = 1'b1;
            w_flush_E = 1'b1;
          end
        end
        MEM_WAIT: begin
          w_freeze = 1'b1;
          if (bus.dmem_ack) begin
            w_state_nxt = RUN;
            w_wcnt_nxt  = '0;
          end else if (r_wcnt == WCNT_W'(TIMEOUT)) begin
            w_set_err   = 1'b1;
            w_state_nxt = RUN;
            w_wcnt_nxt  = '0;
          end else begin
            w_wcnt_nxt = r_wcnt + WCNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = RUN;
          w_wcnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_wcnt      <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      if (w_set_err)
        r_mem_err <= 1'b1;
      if ((w_stall_F || w_freeze) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_acc && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign bus.stall_F   = w_stall_F;
  assign bus.stall_D   = w_stall_D;
  assign bus.flush_D   = w_flush_D;
  assign bus.flush_E   = w_flush_E;
  assign bus.flush_M   = w_flush_M;
  assign bus.freeze    = w_freeze;
  assign bus.mem_err   = r_mem_err;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default instance plus a CNT_W=4 instance sharing the same stimulus.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(16)) ifm ();
  hazard_ctrl_if #(.CNT_W(4))  if4 ();

  assign if4.memRead_E  = ifm.memRead_E;
  assign if4.Rd_E       = ifm.Rd_E;
  assign if4.Rn_D       = ifm.Rn_D;
  assign if4.Rm_D       = ifm.Rm_D;
  assign if4.useRm_D    = ifm.useRm_D;
  assign if4.PCSrc_M    = ifm.PCSrc_M;
  assign if4.dmem_req_M = ifm.dmem_req_M;
  assign if4.dmem_ack   = ifm.dmem_ack;

  hazard_ctrl #(.TIMEOUT(15), .CNT_W(16)) u_dut  (.clk(clk), .reset(reset), .bus(ifm));
  hazard_ctrl #(.TIMEOUT(15), .CNT_W(4))  u_dut4 (.clk(clk), .reset(reset), .bus(if4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // {stall_F, stall_D, flush_D, flush_E, flush_M, freeze}
  function automatic logic [5:0] ctl();
    return {ifm.stall_F, ifm.stall_D, ifm.flush_D, ifm.flush_E, ifm.flush_M, ifm.freeze};
  endfunction

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rn,
                       input logic [4:0] rm, input logic um, input logic pc,
                       input logic req, input logic ack);
    ifm.memRead_E  = mr;
    ifm.Rd_E       = rd;
    ifm.Rn_D       = rn;
    ifm.Rm_D       = rm;
    ifm.useRm_D    = um;
    ifm.PCSrc_M    = pc;
    ifm.dmem_req_M = req;
    ifm.dmem_ack   = ack;
  endtask

  // Check combinational controls mid-cycle, then advance past the rising edge.
  task automatic cyc(input string tag, input logic [5:0] exp);
    #1;
    chk(tag, 32'(ctl()), 32'(exp));
    @(negedge clk);
  endtask

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_LU   = 6'b110100;
  localparam logic [5:0] C_BR   = 6'b001110;
  localparam logic [5:0] C_FRZ  = 6'b000001;

  initial begin
    // Reset with a live load-use pattern: outputs must be forced low.
    reset = 1'b1;
    drive(1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("rst_ctl", C_NONE);
    chk("rst_stall_cnt", 32'(ifm.stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(ifm.flush_cnt), 32'd0);
    chk("rst_mem_err", 32'(ifm.mem_err), 32'd0);
    chk("rst_stall_cnt4", 32'(if4.stall_cnt), 32'd0);
    reset = 1'b0;

    // Load-use detection variants.
    drive(1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu_rn", C_LU);
    chk("lu_stall_cnt1", 32'(ifm.stall_cnt), 32'd1);
    drive(1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("lu_xzr", C_NONE);
    chk("xzr_stall_cnt", 32'(ifm.stall_cnt), 32'd1);
    drive(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("lu_rm", C_LU);
    drive(1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu_rm_unused", C_NONE);
    drive(1'b0, 5'd2, 5'd2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("no_load", C_NONE);
    chk("lu_stall_cnt2", 32'(ifm.stall_cnt), 32'd2);

    // Taken branch overrides a simultaneous load-use.
    drive(1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("branch_lu", C_BR);
    chk("br_flush_cnt", 32'(ifm.flush_cnt), 32'd1);
    chk("br_stall_cnt", 32'(ifm.stall_cnt), 32'd2);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("idle", C_NONE);

    // Memory wait acknowledged after three waiting cycles.
    reset = 1'b1;
    cyc("rst2_ctl", C_NONE);
    reset = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("mw_run", C_FRZ);
    cyc("mw_w1", C_FRZ);
    cyc("mw_w2", C_FRZ);
    ifm.dmem_ack = 1'b1;
    cyc("mw_ack", C_FRZ);
    chk("mw_stall_cnt", 32'(ifm.stall_cnt), 32'd4);
    chk("mw_mem_err", 32'(ifm.mem_err), 32'd0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("mw_released", C_NONE);
    // Single-cycle access does not freeze; load-use still applies.
    drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc("single_access_lu", C_LU);
    chk("single_stall_cnt", 32'(ifm.stall_cnt), 32'd5);

    // Timeout: 16 frozen cycles, then sticky error.
    reset = 1'b1;
    cyc("rst3_ctl", C_NONE);
    reset = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      if (i > 1) chk($sformatf("to_err_low_%0d", i), 32'(ifm.mem_err), 32'd0);
      cyc($sformatf("to_freeze_%0d", i), C_FRZ);
    end
    chk("to_mem_err", 32'(ifm.mem_err), 32'd1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("to_released", C_NONE);
    cyc("to_idle", C_NONE);
    chk("to_mem_err_sticky", 32'(ifm.mem_err), 32'd1);
    chk("to_stall_cnt", 32'(ifm.stall_cnt), 32'd16);

    // Reset in the second MEM_WAIT cycle.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("rw_run", C_FRZ);
    reset = 1'b1;
    cyc("rw_reset_cycle", C_NONE);
    reset = 1'b0;
    chk("rw_mem_err", 32'(ifm.mem_err), 32'd0);
    chk("rw_stall_cnt", 32'(ifm.stall_cnt), 32'd0);
    chk("rw_flush_cnt", 32'(ifm.flush_cnt), 32'd0);
    ifm.dmem_ack = 1'b1;
    cyc("rw_state_run", C_NONE);

    // Saturation on the CNT_W=4 instance.
    reset = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("rst4_ctl", C_NONE);
    reset = 1'b0;
    drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      cyc($sformatf("sat_lu_%0d", i), C_LU);
      if (i == 14) chk("sat_cnt4_14", 32'(if4.stall_cnt), 32'd14);
      if (i == 15) chk("sat_cnt4_15", 32'(if4.stall_cnt), 32'd15);
    end
    chk("sat_cnt4_20", 32'(if4.stall_cnt), 32'd15);
    chk("sat_cnt16_20", 32'(ifm.stall_cnt), 32'd20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the five-stage LEGv8 core (IF, ID, EX, MEM, WB).
- Consumes the branch decision PCSrc_M produced in MEM, load-use information from ID/EX and the data-memory handshake.
- Drives stall enables for PC/IF-ID and flush (bubble) controls for IF-ID, ID-EX and EX-MEM.
- Holds a small FSM for multi-cycle data-memory waits with timeout, plus saturating performance counters.

Parameters:
- TIMEOUT, 15: maximum consecutive cycles in MEM_WAIT before forced release and error.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- memRead_E  in  1  instruction in EX is a load (LDUR).
- Rd_E  in  5  destination register of the instruction in EX.
- Rn_D  in  5  first source register of the instruction in ID.
- Rm_D  in  5  second source register of the instruction in ID (Rt for STUR/CBZ).
- useRm_D  in  1  ID instruction actually reads Rm_D.
- PCSrc_M  in  1  taken branch resolved in MEM (Branch_M && zero_M, or B.cond true).
- dmem_req_M  in  1  instruction in MEM accesses data memory this cycle.
- dmem_ack  in  1  data memory completes the access this cycle.
- stall_F  out  1  hold PC.
- stall_D  out  1  hold IF/ID register.
- flush_D  out  1  zero IF/ID register.
- flush_E  out  1  zero ID/EX register (insert bubble).
- flush_M  out  1  zero EX/MEM register.
- freeze  out  1  hold every pipeline register (memory wait).
- mem_err  out  1  sticky: a memory access timed out.
- stall_cnt  out  CNT_W  cycles with stall_F or freeze asserted.
- flush_cnt  out  CNT_W  taken-branch flush events.

Behaviour:
- Reset (synchronous, active-high): state=RUN, wait counter=0, mem_err=0, stall_cnt=0, flush_cnt=0. During a reset cycle all combinational outputs are forced to 0.
- States are RUN and MEM_WAIT. Outputs are combinational from the current state and inputs, with zero latency. Counters and state update at the clock edge.
- Load-use hazard is detected as `LU = memRead_E && Rd_E!=31 && (Rn_D==Rd_E || (useRm_D && Rm_D==Rd_E))`. Register X31 (XZR) never causes a hazard.
- RUN priority, highest first:
  1. Memory wait: if dmem_req_M && !dmem_ack, then freeze=1 and all other outputs are 0. The state goes to MEM_WAIT and the wait counter is set to 1.
  2. Taken branch: if PCSrc_M, then flush_D=flush_E=flush_M=1 and stall_F=stall_D=0, so the PC loads the target. flush_cnt increments. A simultaneous LU is ignored because the ID instruction is being squashed.
  3. Load-use: if LU, then stall_F=stall_D=1 and flush_E=1 for exactly one cycle. Next cycle the load is in MEM, LU is re-evaluated and is normally false.
  4. Otherwise all outputs are 0.
- A dmem_req_M with dmem_ack in the same cycle is a single-cycle access: no freeze, and the remaining priorities apply normally.
- MEM_WAIT:
  - freeze=1 and all stall/flush outputs are 0.
  - If dmem_ack: go to RUN and clear the wait counter. freeze is still 1 in the ack cycle; the pipeline advances on the next cycle.
  - Else if the wait counter equals TIMEOUT: set mem_err=1 (sticky until reset), go to RUN and clear the counter.
  - Else the wait counter increments.
- PCSrc_M asserted while in MEM_WAIT is ignored. A branch and a memory access are never in MEM together; the bench treats this as illegal stimulus.
- Counters:
  - stall_cnt increments on every cycle where stall_F||freeze.
  - flush_cnt increments on every cycle where PCSrc_M is accepted in RUN.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset mid-MEM_WAIT returns to RUN immediately and deasserts freeze in the reset cycle.
- The wait counter is wide enough for TIMEOUT, i.e. $clog2(TIMEOUT+1) bits.

Test Plan:
- LDUR X2 in EX (memRead_E=1, Rd_E=2) with ADD in ID reading Rn_D=2 → stall_F=stall_D=flush_E=1 for one cycle, stall_cnt=1. Repeat with Rd_E=31 → no stall.
- PCSrc_M=1 with LU also true → flush_D=flush_E=flush_M=1, stall_F=0, flush_cnt=1.
- dmem_req_M=1, dmem_ack low for 3 cycles then high → freeze high for 4 cycles, state back to RUN, stall_cnt=4, mem_err=0.
- dmem_req_M=1 with dmem_ack never asserted, TIMEOUT=15 → freeze high 16 cycles, then mem_err=1 and it stays 1 until reset.
- Assert reset in the 2nd MEM_WAIT cycle → freeze=0 in that cycle; next cycle: state RUN, counters 0, mem_err 0.
- CNT_W=4: 20 consecutive load-use stalls → stall_cnt saturates at 15.
